// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: serializes a held stereo sample pair into a Philips I2S stream.
// BCLK/LRCLK free-run from clk. Samples pass through one holding register
// into the per-frame shift source. Underrun and overrun are flagged as pulses.
module i2s_dac_tx #(
    parameter int DAC_WIDTH     = 16,
    parameter int SLOT_WIDTH    = 32,
    parameter int BCLK_HALF_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_clk_en,
    input  logic [DAC_WIDTH-1:0] dac_input_l,
    input  logic [DAC_WIDTH-1:0] dac_input_r,
    output logic                 i2s_bclk,
    output logic                 i2s_lrclk,
    output logic                 i2s_data,
    output logic                 frame_start,
    output logic                 underrun,
    output logic                 overrun
);
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_WIDTH);
    localparam logic [CNT_W-1:0] DW_C     = CNT_W'(DAC_WIDTH);

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 bclk_q, bclk_d;
    logic [CNT_W-1:0]     bit_q, bit_d;
    logic                 lrclk_q, lrclk_d;
    logic                 data_q, data_d;
    logic [DAC_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic                 pending_q, pending_d;
    logic [DAC_WIDTH-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic                 frame_start_q, frame_start_d;
    logic                 underrun_q, underrun_d;
    logic                 overrun_q, overrun_d;

    logic                 tick, fall, wrap;
    logic [CNT_W-1:0]     bit_nx, pos_nx;
    logic                 slot_nx, bit_val;
    logic [DAC_WIDTH-1:0] word, shifted;

    // Event decode and the serial bit that goes out at the next BCLK fall.
    // Slot position 0 is the I2S one-bit delay; positions past the sample
    // width are zero-filled.
    always_comb begin
        tick    = (div_q == DIV_LAST);
        fall    = tick && bclk_q;
        wrap    = fall && (bit_q == BIT_LAST);
        bit_nx  = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        slot_nx = (bit_nx >= SLOT_C);
        pos_nx  = slot_nx ? (bit_nx - SLOT_C) : bit_nx;
        word    = slot_nx ? frame_r_q : frame_l_q;
        shifted = word << (pos_nx - 1'b1);
        bit_val = ((pos_nx != '0) && (pos_nx <= DW_C)) ? shifted[DAC_WIDTH-1] : 1'b0;
    end

    // Next-state logic for the bit-clock generator, serializer and sample handoff.
    always_comb begin
        div_d         = tick ? '0 : div_q + 1'b1;
        bclk_d        = tick ? ~bclk_q : bclk_q;
        bit_d         = bit_q;
        lrclk_d       = lrclk_q;
        data_d        = data_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        pending_d     = pending_q;
        frame_l_d     = frame_l_q;
        frame_r_d     = frame_r_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        overrun_d     = 1'b0;

        if (fall) begin
            bit_d   = bit_nx;
            lrclk_d = slot_nx;
            data_d  = bit_val;
        end

        // Holding register always tracks the newest sample so that a later
        // underrun repeats the most recent pair, including a bypassed one.
        if (sample_clk_en) begin
            hold_l_d = dac_input_l;
            hold_r_d = dac_input_r;
        end

        if (wrap) begin
            frame_start_d = 1'b1;
            pending_d     = 1'b0;
            if (sample_clk_en) begin
                frame_l_d = dac_input_l;
                frame_r_d = dac_input_r;
            end else begin
                frame_l_d  = hold_l_q;
                frame_r_d  = hold_r_q;
                underrun_d = ~pending_q;
            end
        end else if (sample_clk_en) begin
            pending_d = 1'b1;
            overrun_d = pending_q;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            bclk_q        <= 1'b0;
            bit_q         <= '0;
            lrclk_q       <= 1'b0;
            data_q        <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            pending_q     <= 1'b0;
            frame_l_q     <= '0;
            frame_r_q     <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            bit_q         <= bit_d;
            lrclk_q       <= lrclk_d;
            data_q        <= data_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            pending_q     <= pending_d;
            frame_l_q     <= frame_l_d;
            frame_r_q     <= frame_r_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    assign i2s_bclk    = bclk_q;
    assign i2s_lrclk   = lrclk_q;
    assign i2s_data    = data_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Testbench for i2s_dac_tx: table-driven sample pairs, hand-written underrun,
// overrun, bypass and rate-lock sequences, and mid-frame reset. Expected
// frames go into a scoreboard queue when the stimulus is driven and are
// compared against the serial stream captured on BCLK rising edges.
module tb_i2s_dac_tx;
    localparam int FRAME = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_clk_en = 1'b0;
    logic [15:0] dac_input_l = '0;
    logic [15:0] dac_input_r = '0;
    logic        i2s_bclk, i2s_lrclk, i2s_data, frame_start, underrun, overrun;

    i2s_dac_tx #(.DAC_WIDTH(16), .SLOT_WIDTH(32), .BCLK_HALF_DIV(2)) dut (
        .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en),
        .dac_input_l(dac_input_l), .dac_input_r(dac_input_r),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_data(i2s_data),
        .frame_start(frame_start), .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Clock edges seen since reset release; drives the timing reference.
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct packed {
        logic [63:0] frm;
        logic        ur;
    } sb_t;
    sb_t sb_q[$];
    sb_t cur;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;
    vec_t vecs[5];

    int fs_cnt = 0, ur_cnt = 0, ov_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mk_frame(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
    endfunction

    // Monitor: clock-frame timing, event counters, serial capture on BCLK rise.
    logic        coll = 1'b0;
    int          idx = 0;
    logic        prev_bclk = 1'b0;
    logic [63:0] cap;
    always @(negedge clk) begin
        if (reset) begin
            coll      = 1'b0;
            prev_bclk = 1'b0;
        end else begin
            chk("bclk_phase", i2s_bclk, 64'((cyc >> 1) & 1));
            chk("lrclk_phase", i2s_lrclk, 64'(((cyc / 4) % 64) >= 32));
            chk("frame_start_timing", frame_start, 64'((cyc > 0) && (cyc % FRAME == 0)));
            if (frame_start) fs_cnt++;
            if (underrun) ur_cnt++;
            if (overrun) ov_cnt++;
            if (coll && i2s_bclk && !prev_bclk) begin
                cap[63-idx] = i2s_data;
                idx++;
                if (idx == 64) begin
                    chk("frame_data", cap, cur.frm);
                    $display("frame done cyc=%0d data=%h", cyc, cap);
                    coll = 1'b0;
                end
            end
            if (frame_start) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 64'(sb_q.size()), 64'd1);
                end else begin
                    cur = sb_q.pop_front();
                    chk("underrun_at_load", underrun, cur.ur);
                    coll = 1'b1;
                    idx  = 0;
                end
            end
            prev_bclk = i2s_bclk;
        end
    end

    // Drive one sample_clk_en so it is seen at clock edge number c.
    task automatic en_at(input int c, input logic [15:0] l, input logic [15:0] r);
        if (cyc > c - 1) chk("schedule_late", 64'(cyc), 64'(c - 1));
        while (cyc < c - 1) @(negedge clk);
        sample_clk_en = 1'b1;
        dac_input_l   = l;
        dac_input_r   = r;
        $display("sample cyc=%0d l=%h r=%h", c, l, r);
        @(negedge clk);
        sample_clk_en = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Bounded wait for BCLK (sel=0) or LRCLK (sel=1) to reach a level.
    task automatic wait_sig(input int sel, input logic val, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (((sel == 0) ? i2s_bclk : i2s_lrclk) == val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("wait_timeout", 64'(sel), 64'hFF);
    endtask

    initial begin
        int ur0, ov0, fs0, a, b;
        logic ok, hit;
        logic [15:0] rl, rr;
        logic [63:0] last;

        vecs[0] = '{16'h8001, 16'h7FFE, 32'h4000_8000, 32'h3FFF_0000};
        vecs[1] = '{16'hA5A5, 16'h5A5A, 32'h52D2_8000, 32'h2D2D_0000};
        vecs[2] = '{16'hFFFF, 16'h0000, 32'h7FFF_8000, 32'h0000_0000};
        vecs[3] = '{16'h0000, 16'hFFFF, 32'h0000_0000, 32'h7FFF_8000};
        vecs[4] = '{16'h1234, 16'h8000, 32'h091A_0000, 32'h4000_0000};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {i2s_bclk, i2s_lrclk, i2s_data, frame_start, underrun, overrun}, 64'd0);
        sb_q.push_back('{64'd0, 1'b1});   // first load: nothing held yet
        reset = 1'b0;

        // Table: one sample per frame, each carried by the following frame.
        for (int i = 0; i < 5; i++) begin
            en_at(FRAME * (i + 1) + 100, vecs[i].l, vecs[i].r);
            sb_q.push_back('{{vecs[i].exp_l, vecs[i].exp_r}, 1'b0});
        end
        last = {vecs[4].exp_l, vecs[4].exp_r};

        // Underrun: no sample before load 7, previous pair repeats.
        ur0 = ur_cnt;
        sb_q.push_back('{last, 1'b1});
        wait_until(FRAME * 7 + 10);
        chk("underrun_count", 64'(ur_cnt - ur0), 64'd1);

        // Overrun: two samples inside one frame, the newer one wins.
        ov0 = ov_cnt;
        en_at(FRAME * 7 + 50, 16'h1234, 16'h1111);
        en_at(FRAME * 7 + 150, 16'h5678, 16'h2222);
        sb_q.push_back('{mk_frame(16'h5678, 16'h2222), 1'b0});
        wait_until(FRAME * 8 + 10);
        chk("overrun_count", 64'(ov_cnt - ov0), 64'd1);
        chk("overrun_frame_expect", mk_frame(16'h5678, 16'h2222), 64'h2B3C_0000_1111_0000);

        // Sample arriving on the exact load edge bypasses into the frame.
        ur0 = ur_cnt;
        ov0 = ov_cnt;
        sb_q.push_back('{mk_frame(16'hA5A5, 16'hA5A5), 1'b0});
        en_at(FRAME * 9, 16'hA5A5, 16'hA5A5);
        wait_until(FRAME * 9 + 10);
        chk("bypass_underrun", 64'(ur_cnt - ur0), 64'd0);
        chk("bypass_overrun", 64'(ov_cnt - ov0), 64'd0);

        // Rate lock: one sample per frame for 64 frames.
        ur0 = ur_cnt;
        ov0 = ov_cnt;
        fs0 = fs_cnt;
        for (int k = 0; k < 64; k++) begin
            rl = 16'($urandom) | 16'h0001;
            rr = 16'($urandom);
            sb_q.push_back('{mk_frame(rl, rr), 1'b0});
            en_at(FRAME * (9 + k) + 128, rl, rr);
            last = mk_frame(rl, rr);
        end
        wait_until(FRAME * 73 + 10);
        chk("rate_frame_starts", 64'(fs_cnt - fs0), 64'd64);
        chk("rate_underruns", 64'(ur_cnt - ur0), 64'd0);
        chk("rate_overruns", 64'(ov_cnt - ov0), 64'd0);

        // Mid-frame reset while data is high.
        sb_q.push_back('{last, 1'b1});
        wait_until(FRAME * 74 + 10);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i2s_data) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("data_high_before_reset", hit, 1'b1);
        #1 reset = 1'b1;
        #1 chk("async_reset_outputs",
               {i2s_bclk, i2s_lrclk, i2s_data, frame_start, underrun, overrun}, 64'd0);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        sb_q.push_back('{64'd0, 1'b1});
        reset = 1'b0;

        // Periods after release.
        wait_sig(0, 1'b1, ok); a = cyc;
        wait_sig(0, 1'b0, ok);
        wait_sig(0, 1'b1, ok); b = cyc;
        chk("bclk_period", 64'(b - a), 64'd4);
        wait_sig(1, 1'b1, ok); a = cyc;
        wait_sig(1, 1'b0, ok);
        wait_sig(1, 1'b1, ok); b = cyc;
        chk("lrclk_period", 64'(b - a), 64'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
